// File: rtl/pong_motion_ctrl.sv
// Frame-rate motion engine: bar from buttons, bouncing 8x8 ball, IDLE/PLAY/MISS sequencing.
// All updates on the once-per-frame refresh tick, outputs registered 1 clk later; no backpressure.
module pong_motion_ctrl #(
  parameter int MAX_X       = 640,
  parameter int MAX_Y       = 480,
  parameter int WALL_Y_B    = 35,
  parameter int BAR_Y_T     = 450,
  parameter int BAR_X_SIZE  = 72,
  parameter int BAR_V       = 4,
  parameter int BALL_SIZE   = 8,
  parameter int BALL_V      = 2,
  parameter int MISS_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       start,
  output logic [9:0] bar_x_l,
  output logic [9:0] ball_x_l,
  output logic [9:0] ball_y_t,
  output logic       game_on,
  output logic       miss
);

  localparam int CNT_W = $clog2(MISS_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MISS_FRAMES - 1);

  localparam logic [9:0] BAR_X_MAX   = 10'(MAX_X - BAR_X_SIZE);
  localparam logic [9:0] BAR_X_RST   = 10'((MAX_X - BAR_X_SIZE) / 2);
  localparam logic [9:0] BALL_X_PARK = 10'((MAX_X - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_Y_PARK = 10'(425);

  localparam logic signed [10:0] BALL_V_S     = 11'(BALL_V);
  localparam logic signed [10:0] BALL_X_MAX_S = 11'(MAX_X - BALL_SIZE);
  localparam logic signed [10:0] WALL_S       = 11'(WALL_Y_B);
  localparam logic signed [10:0] BAR_Y_S      = 11'(BAR_Y_T);
  localparam logic signed [10:0] EDGE_S       = 11'(BALL_SIZE - 1);
  localparam logic signed [10:0] BAR_W_S      = 11'(BAR_X_SIZE - 1);
  localparam logic signed [10:0] MISS_Y_S     = 11'(MAX_Y - BALL_SIZE);

  typedef enum logic [1:0] {IDLE, PLAY, MISS} state_t;

  state_t           state_q, state_d;
  logic             refr_cond_q, refr_cond_d;
  logic [9:0]       bar_x_q, bar_x_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic             dx_pos_q, dx_pos_d;
  logic             dy_pos_q, dy_pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             miss_q, miss_d;
  logic             game_on_q, game_on_d;

  logic             refr_cond, refr_tick;
  logic             dx_pos_eff, dy_pos_eff, bar_hit;
  logic signed [10:0] x_s, y_s, bar_s, nx, ny, step_x, step_y;
  logic             step_dx_pos, step_dy_pos;
  logic [10:0]      bar_up;

  always_comb begin
    refr_cond   = (pix_y == 10'd481) && (pix_x == 10'd0);
    refr_tick   = refr_cond && !refr_cond_q;
    refr_cond_d = refr_cond;

    state_d  = state_q;
    bar_x_d  = bar_x_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dx_pos_d = dx_pos_q;
    dy_pos_d = dy_pos_q;
    cnt_d    = cnt_q;
    miss_d   = 1'b0;

    // The launch tick already takes the first step from the parked position.
    dx_pos_eff = (state_q == IDLE) ? 1'b1 : dx_pos_q;
    dy_pos_eff = (state_q == IDLE) ? 1'b0 : dy_pos_q;

    x_s   = $signed({1'b0, ball_x_q});
    y_s   = $signed({1'b0, ball_y_q});
    bar_s = $signed({1'b0, bar_x_q});
    nx    = dx_pos_eff ? x_s + BALL_V_S : x_s - BALL_V_S;
    ny    = dy_pos_eff ? y_s + BALL_V_S : y_s - BALL_V_S;

    bar_hit = dy_pos_eff && (y_s + EDGE_S < BAR_Y_S) && (ny + EDGE_S >= BAR_Y_S) &&
              (x_s + EDGE_S >= bar_s) && (x_s <= bar_s + BAR_W_S);

    step_x      = nx;
    step_dx_pos = dx_pos_eff;
    if (nx <= 11'sd0) begin
      step_x      = 11'sd0;
      step_dx_pos = 1'b1;
    end else if (nx >= BALL_X_MAX_S) begin
      step_x      = BALL_X_MAX_S;
      step_dx_pos = 1'b0;
    end

    step_y      = ny;
    step_dy_pos = dy_pos_eff;
    if (ny <= WALL_S) begin
      step_y      = WALL_S + 11'sd1;
      step_dy_pos = 1'b1;
    end else if (bar_hit) begin
      step_y      = BAR_Y_S - EDGE_S - 11'sd1;
      step_dy_pos = 1'b0;
    end

    bar_up = {1'b0, bar_x_q} + 11'(BAR_V);

    if (refr_tick) begin
      if (btn_right && !btn_left) begin
        bar_x_d = (bar_up > {1'b0, BAR_X_MAX}) ? BAR_X_MAX : bar_up[9:0];
      end else if (btn_left && !btn_right) begin
        bar_x_d = (bar_x_q < 10'(BAR_V)) ? 10'd0 : bar_x_q - 10'(BAR_V);
      end

      case (state_q)
        IDLE, PLAY: begin
          if (state_q == PLAY || start) begin
            state_d  = PLAY;
            ball_x_d = step_x[9:0];
            ball_y_d = step_y[9:0];
            dx_pos_d = step_dx_pos;
            dy_pos_d = step_dy_pos;
            if (step_y >= MISS_Y_S) begin
              state_d = MISS;
              miss_d  = 1'b1;
              cnt_d   = '0;
            end
          end
        end
        MISS: begin
          if (cnt_q == CNT_LAST) begin
            state_d  = IDLE;
            ball_x_d = BALL_X_PARK;
            ball_y_d = BALL_Y_PARK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    game_on_d = (state_d == PLAY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      refr_cond_q <= 1'b0;
      bar_x_q     <= BAR_X_RST;
      ball_x_q    <= BALL_X_PARK;
      ball_y_q    <= BALL_Y_PARK;
      dx_pos_q    <= 1'b1;
      dy_pos_q    <= 1'b0;
      cnt_q       <= '0;
      miss_q      <= 1'b0;
      game_on_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      refr_cond_q <= refr_cond_d;
      bar_x_q     <= bar_x_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_pos_q    <= dx_pos_d;
      dy_pos_q    <= dy_pos_d;
      cnt_q       <= cnt_d;
      miss_q      <= miss_d;
      game_on_q   <= game_on_d;
    end
  end

  assign bar_x_l  = bar_x_q;
  assign ball_x_l = ball_x_q;
  assign ball_y_t = ball_y_q;
  assign game_on  = game_on_q;
  assign miss     = miss_q;

endmodule

// File: tb/tb_pong_motion_ctrl.sv
// Scoreboard bench for pong_motion_ctrl: a frame-level reference model predicts every tick.
// Frames are compressed to a few clocks; one test uses a full 525-line scan.
module tb_pong_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pix_x, pix_y;
  logic       btn_left, btn_right, start;
  logic [9:0] bar_x_l, ball_x_l, ball_y_t;
  logic       game_on, miss;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   bar;
    int   x;
    int   y;
    logic on;
    logic miss;
  } exp_t;

  exp_t sb[$];

  // Reference model state: 0=IDLE 1=PLAY 2=MISS
  int   m_state, m_bar, m_x, m_y, m_dx, m_dy, m_cnt;
  logic m_miss, m_on;

  pong_motion_ctrl dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .btn_left(btn_left), .btn_right(btn_right), .start(start),
    .bar_x_l(bar_x_l), .ball_x_l(ball_x_l), .ball_y_t(ball_y_t),
    .game_on(game_on), .miss(miss)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_bar = 284; m_x = 316; m_y = 425;
    m_dx = 2; m_dy = -2; m_cnt = 0; m_miss = 1'b0; m_on = 1'b0;
    sb.delete();
  endtask

  task automatic model_step(input logic l, input logic r, input logic st);
    int bar0, x0, y0, dx, dy, nx, ny;
    bar0 = m_bar; x0 = m_x; y0 = m_y;
    m_miss = 1'b0;
    if ((m_state == 0 && st) || m_state == 1) begin
      dx = (m_state == 0) ? 2 : m_dx;
      dy = (m_state == 0) ? -2 : m_dy;
      nx = x0 + dx;
      ny = y0 + dy;
      if (nx <= 0) begin m_x = 0; dx = 2; end
      else if (nx >= 632) begin m_x = 632; dx = -2; end
      else m_x = nx;
      if (ny <= 35) begin m_y = 36; dy = 2; end
      else if (dy > 0 && y0 + 7 < 450 && ny + 7 >= 450 && x0 + 7 >= bar0 && x0 <= bar0 + 71) begin
        m_y = 442; dy = -2;
      end else m_y = ny;
      m_dx = dx; m_dy = dy; m_state = 1;
      if (m_y >= 472) begin m_state = 2; m_miss = 1'b1; m_cnt = 0; end
    end else if (m_state == 2) begin
      if (m_cnt == 29) begin m_state = 0; m_x = 316; m_y = 425; end
      else m_cnt++;
    end
    if (r && !l) m_bar = (m_bar + 4 > 568) ? 568 : m_bar + 4;
    else if (l && !r) m_bar = (m_bar < 4) ? 0 : m_bar - 4;
    m_on = (m_state == 1);
  endtask

  // One compressed frame: refresh condition held 2 clks, checked at the tick and one clk later.
  task automatic frame(input logic l, input logic r, input logic st);
    exp_t e;
    @(negedge clk);
    btn_left = l; btn_right = r; start = st;
    pix_x = 10'd7; pix_y = 10'd100;
    model_step(l, r, st);
    e.bar = m_bar; e.x = m_x; e.y = m_y; e.on = m_on; e.miss = m_miss;
    sb.push_back(e);
    @(negedge clk);
    pix_x = 10'd0; pix_y = 10'd481;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({bar_x_l, ball_x_l, ball_y_t, game_on, miss} !==
        {10'(e.bar), 10'(e.x), 10'(e.y), e.on, e.miss}) begin
      errors++;
      $display("FAIL frame_tick: got bar=%0d x=%0d y=%0d on=%b miss=%b, expected bar=%0d x=%0d y=%0d on=%b miss=%b",
               bar_x_l, ball_x_l, ball_y_t, game_on, miss, e.bar, e.x, e.y, e.on, e.miss);
    end
    @(negedge clk);
    checks++;
    if (miss !== 1'b0 || bar_x_l !== 10'(e.bar) || ball_y_t !== 10'(e.y)) begin
      errors++;
      $display("FAIL frame_hold: got miss=%b bar=%0d y=%0d, expected miss=0 bar=%0d y=%0d",
               miss, bar_x_l, ball_y_t, e.bar, e.y);
    end
    pix_x = 10'd1;
  endtask

  function automatic logic [1:0] track();
    int tgt;
    tgt = m_x - 32;
    if (tgt < 0) tgt = 0;
    if (tgt > 568) tgt = 568;
    if (m_bar + 4 <= tgt) return 2'b01;
    if (m_bar >= tgt + 4) return 2'b10;
    return 2'b00;
  endfunction

  task automatic test_reset();
    reset = 1'b1; pix_x = 10'd0; pix_y = 10'd0;
    btn_left = 1'b0; btn_right = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bar_x_l, ball_x_l, ball_y_t, game_on, miss} !== {10'd284, 10'd316, 10'd425, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got bar=%0d x=%0d y=%0d on=%b miss=%b, expected 284/316/425/0/0",
               bar_x_l, ball_x_l, ball_y_t, game_on, miss);
    end
    reset = 1'b0;
    model_reset();
    frame(1'b0, 1'b1, 1'b1);
    frame(1'b0, 1'b1, 1'b0);
    frame(1'b0, 1'b1, 1'b0);
    checks++;
    if (game_on !== 1'b1 || bar_x_l !== 10'd296) begin
      errors++;
      $display("FAIL pre_reset_play: got on=%b bar=%0d, expected on=1 bar=296", game_on, bar_x_l);
    end
    @(negedge clk);
    pix_x = 10'd0; pix_y = 10'd481;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bar_x_l, ball_x_l, ball_y_t, game_on, miss} !== {10'd284, 10'd316, 10'd425, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_midframe: got bar=%0d x=%0d y=%0d on=%b miss=%b, expected 284/316/425/0/0",
               bar_x_l, ball_x_l, ball_y_t, game_on, miss);
    end
    @(negedge clk);
    pix_x = 10'd0; pix_y = 10'd0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_bar_move();
    repeat (10) frame(1'b0, 1'b1, 1'b0);
    checks++;
    if (bar_x_l !== 10'd324) begin
      errors++;
      $display("FAIL bar_right_10: got %0d expected 324", bar_x_l);
    end
    repeat (65) frame(1'b0, 1'b1, 1'b0);
    checks++;
    if (bar_x_l !== 10'd568) begin
      errors++;
      $display("FAIL bar_saturate: got %0d expected 568", bar_x_l);
    end
    repeat (5) frame(1'b1, 1'b1, 1'b0);
    checks++;
    if (bar_x_l !== 10'd568) begin
      errors++;
      $display("FAIL bar_both_hold: got %0d expected 568", bar_x_l);
    end
  endtask

  task automatic test_frame_tick();
    int changes;
    logic [9:0] prev;
    changes = 0;
    btn_left = 1'b1; btn_right = 1'b0; start = 1'b0;
    prev = bar_x_l;
    for (int f = 0; f < 3; f++) begin
      for (int y = 0; y < 525; y++) begin
        for (int x = 0; x < 4; x++) begin
          @(negedge clk);
          if (bar_x_l !== prev) changes++;
          prev = bar_x_l;
          pix_x = 10'(x); pix_y = 10'(y);
          if (y == 481 && x == 0) model_step(1'b1, 1'b0, 1'b0);
          @(negedge clk);
          if (bar_x_l !== prev) changes++;
          prev = bar_x_l;
        end
      end
    end
    checks++;
    if (changes !== 3) begin
      errors++;
      $display("FAIL tick_per_frame: got %0d bar updates expected 3", changes);
    end
    checks++;
    if (bar_x_l !== 10'd556 || bar_x_l !== 10'(m_bar)) begin
      errors++;
      $display("FAIL tick_scan_bar: got %0d expected 556 (model %0d)", bar_x_l, m_bar);
    end
  endtask

  task automatic test_launch_wall();
    int n;
    frame(1'b0, 1'b0, 1'b1);
    checks++;
    if ({ball_x_l, ball_y_t, game_on} !== {10'd318, 10'd423, 1'b1}) begin
      errors++;
      $display("FAIL launch: got x=%0d y=%0d on=%b expected 318/423/1", ball_x_l, ball_y_t, game_on);
    end
    n = 0;
    while (m_y != 36 && n < 400) begin
      frame(1'b0, 1'b0, 1'b0);
      n++;
    end
    checks++;
    if (n >= 400 || ball_y_t !== 10'd36) begin
      errors++;
      $display("FAIL top_wall: got y=%0d after %0d frames expected 36", ball_y_t, n);
    end
    frame(1'b0, 1'b0, 1'b0);
    checks++;
    if (ball_y_t !== 10'd38) begin
      errors++;
      $display("FAIL top_wall_bounce: got y=%0d expected 38", ball_y_t);
    end
  endtask

  task automatic test_bar_hit();
    int n;
    logic [1:0] lr;
    n = 0;
    while (!(m_y == 440 && m_dy > 0) && n < 400) begin
      lr = track();
      frame(lr[1], lr[0], 1'b1);
      n++;
    end
    checks++;
    if (n >= 400 || ball_y_t !== 10'd440 || game_on !== 1'b1) begin
      errors++;
      $display("FAIL bar_approach: got y=%0d on=%b after %0d frames expected 440/1", ball_y_t, game_on, n);
    end
    lr = track(); frame(lr[1], lr[0], 1'b0);
    checks++;
    if (ball_y_t !== 10'd442) begin
      errors++;
      $display("FAIL bar_descend: got y=%0d expected 442", ball_y_t);
    end
    lr = track(); frame(lr[1], lr[0], 1'b0);
    checks++;
    if (ball_y_t !== 10'd442) begin
      errors++;
      $display("FAIL bar_clamp: got y=%0d expected 442", ball_y_t);
    end
    lr = track(); frame(lr[1], lr[0], 1'b0);
    checks++;
    if (ball_y_t !== 10'd440) begin
      errors++;
      $display("FAIL bar_rebound: got y=%0d expected 440", ball_y_t);
    end
  endtask

  task automatic test_miss();
    int n, fx;
    n = 0;
    while (!m_miss && n < 3000) begin
      frame(1'b1, 1'b0, 1'b0);
      n++;
    end
    checks++;
    if (n >= 3000 || ball_y_t !== 10'd472 || bar_x_l !== 10'd0 || game_on !== 1'b0) begin
      errors++;
      $display("FAIL miss_event: got y=%0d bar=%0d on=%b after %0d frames expected 472/0/0",
               ball_y_t, bar_x_l, game_on, n);
    end
    fx = m_x;
    repeat (29) frame(1'b1, 1'b0, 1'b0);
    checks++;
    if (ball_x_l !== 10'(fx) || ball_y_t !== 10'd472 || game_on !== 1'b0) begin
      errors++;
      $display("FAIL miss_frozen: got x=%0d y=%0d on=%b expected %0d/472/0", ball_x_l, ball_y_t, game_on, fx);
    end
    frame(1'b1, 1'b0, 1'b0);
    checks++;
    if ({ball_x_l, ball_y_t, game_on, miss} !== {10'd316, 10'd425, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL miss_to_idle: got x=%0d y=%0d on=%b miss=%b expected 316/425/0/0",
               ball_x_l, ball_y_t, game_on, miss);
    end
  endtask

  task automatic test_back_to_back();
    frame(1'b0, 1'b0, 1'b1);
    checks++;
    if ({ball_x_l, ball_y_t, game_on} !== {10'd318, 10'd423, 1'b1}) begin
      errors++;
      $display("FAIL relaunch: got x=%0d y=%0d on=%b expected 318/423/1", ball_x_l, ball_y_t, game_on);
    end
  endtask

  initial begin
    test_reset();
    test_bar_move();
    test_frame_tick();
    test_launch_wall();
    test_bar_hit();
    test_miss();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
